ct_f_spsram_req_ctrl: RTL and testbench

Initiator-side controller for the FPGA single-port SRAM wrappers (`ct_f_spsram_*`). It converts a valid/ready read/write request stream into the SRAM's active-low CEN/GWEN/WEN port protocol and returns read data on a valid/ready response channel. After reset it zero-fills the whole array before accepting requests. It sits between a cache or buffer pipeline and one `ct_f_spsram_<depth>x<width>` instance.

---
 rtl/ct_f_spsram_pkg.sv | 18 +
 rtl/ct_f_spsram_init_walker.sv | 78 +++++++
 rtl/ct_f_spsram_req_ctrl.sv | 105 ++++++++++
 tb/tb_ct_f_spsram_req_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_f_spsram_pkg.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_pkg
// Shared types and helpers for the single-port SRAM request controller.
//   state_e  : controller state (INIT = zero-fill in progress, RUN = serving)
//   depth_of : number of words addressed by an address of the given width
// ---------------------------------------------------------------------------
package ct_f_spsram_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic int unsigned depth_of(input int unsigned addr_w);
      return 32'd1 << addr_w;
   endfunction

endpackage

// File: rtl/ct_f_spsram_init_walker.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_init_walker
// Walks every SRAM address once after reset so the array can be zero-filled,
// then reports completion. Owns the controller INIT/RUN state.
// Ports:
//   clk         in   clock, rising edge
//   rst_b       in   synchronous active-low reset
//   fill_active out  a fill write is issued this cycle
//   fill_addr   out  address of the fill write
//   done        out  fill complete (RUN state); stays high until reset
// ---------------------------------------------------------------------------
module ct_f_spsram_init_walker
   import ct_f_spsram_pkg::*;
#(
   parameter int ADDR_WIDTH = 13,
   parameter int INIT_EN    = 1
) (
   input  logic                  clk,
   input  logic                  rst_b,
   output logic                  fill_active,
   output logic [ADDR_WIDTH-1:0] fill_addr,
   output logic                  done
);

   // Counter value once every address has been written; only the MSB is set.
   localparam logic [ADDR_WIDTH:0] CNT_DONE = (ADDR_WIDTH+1)'(depth_of(ADDR_WIDTH));

   state_e                state_q, state_d;
   logic [ADDR_WIDTH:0]   init_cnt_q, init_cnt_d;
   logic                  active_q, active_d;

   always_ff @(posedge clk) begin
      if (!rst_b) begin
         state_q    <= INIT;
         init_cnt_q <= '0;
         active_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         init_cnt_q <= init_cnt_d;
         active_q   <= active_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      init_cnt_d = init_cnt_q;
      active_d   = active_q;
      case (state_q)
         INIT: begin
            if (active_q) begin
               init_cnt_d = init_cnt_q + 1'b1;
               // Last address written this cycle: the carry lands in the MSB.
               if (init_cnt_q[ADDR_WIDTH-1:0] == {ADDR_WIDTH{1'b1}}) begin
                  active_d = 1'b0;
                  state_d  = RUN;
               end
            end else if (INIT_EN != 0) begin
               // First cycle out of reset is idle; the fill starts next cycle.
               active_d = 1'b1;
            end else begin
               init_cnt_d = CNT_DONE;
               state_d    = RUN;
            end
         end
         RUN: begin
            active_d = 1'b0;
         end
         default: begin
            state_d = INIT;
         end
      endcase
   end

   assign fill_active = active_q;
   assign fill_addr   = init_cnt_q[ADDR_WIDTH-1:0];
   assign done        = (state_q == RUN);

endmodule

// File: rtl/ct_f_spsram_req_ctrl.sv
// ---------------------------------------------------------------------------
// ct_f_spsram_req_ctrl
// Initiator-side controller for a ct_f_spsram_<depth>x<width> wrapper.
// Zero-fills the array after reset, then converts a valid/ready read/write
// request stream into CEN/GWEN/WEN (active-low) accesses and returns read
// data on a valid/ready response channel (1-cycle read latency).
// Ports:
//   forever_cpuclk, cpurst_b                  clock, sync active-low reset
//   req_vld/req_rdy/req_wr/req_addr/
//     req_wdata/req_wmask                     request channel
//   rsp_vld/rsp_rdy/rsp_rdata                 read response channel
//   init_done                                 zero-fill complete
//   sram_a/sram_cen/sram_gwen/sram_wen/
//     sram_d/sram_q                           SRAM port
// ---------------------------------------------------------------------------
module ct_f_spsram_req_ctrl
   import ct_f_spsram_pkg::*;
#(
   parameter int ADDR_WIDTH = 13,
   parameter int DATA_WIDTH = 128,
   parameter int INIT_EN    = 1
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  req_vld,
   output logic                  req_rdy,
   input  logic                  req_wr,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   input  logic [DATA_WIDTH-1:0] req_wmask,
   output logic                  rsp_vld,
   input  logic                  rsp_rdy,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   logic                  fill_active;
   logic [ADDR_WIDTH-1:0] fill_addr;
   logic                  fire;
   logic                  rsp_vld_q, rsp_vld_d;

   ct_f_spsram_init_walker #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .INIT_EN    (INIT_EN)
   ) u_init_walker (
      .clk         (forever_cpuclk),
      .rst_b       (cpurst_b),
      .fill_active (fill_active),
      .fill_addr   (fill_addr),
      .done        (init_done)
   );

   always_ff @(posedge forever_cpuclk) begin
      if (!cpurst_b) begin
         rsp_vld_q <= 1'b0;
      end else begin
         rsp_vld_q <= rsp_vld_d;
      end
   end

   // A stalled response blocks new requests so the SRAM holds its Q output.
   assign req_rdy   = init_done && (!rsp_vld_q || rsp_rdy);
   assign fire      = req_vld && req_rdy;
   assign rsp_vld   = rsp_vld_q;
   assign rsp_rdata = sram_q;

   always_comb begin
      rsp_vld_d = rsp_vld_q;
      if (fire && !req_wr) begin
         rsp_vld_d = 1'b1;
      end else if (rsp_rdy) begin
         rsp_vld_d = 1'b0;
      end
   end

   // SRAM port: fill writes during INIT, otherwise the firing request.
   always_comb begin
      sram_a    = '0;
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_d    = '0;
      if (fill_active) begin
         sram_a    = fill_addr;
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
      end else if (fire) begin
         sram_a   = req_addr;
         sram_cen = 1'b0;
         if (req_wr) begin
            sram_gwen = 1'b0;
            sram_wen  = ~req_wmask;
            sram_d    = req_wdata;
         end
      end
   end

endmodule

// File: tb/tb_ct_f_spsram_req_ctrl.sv
module tb_ct_f_spsram_req_ctrl;
   localparam int AW    = 4;
   localparam int DW    = 16;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // DUT 1: zero-fill enabled
   logic          rst_b;
   logic          req_vld, req_rdy, req_wr;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata, req_wmask;
   logic          rsp_vld, rsp_rdy;
   logic [DW-1:0] rsp_rdata;
   logic          init_done;
   logic [AW-1:0] sram_a;
   logic          sram_cen, sram_gwen;
   logic [DW-1:0] sram_wen, sram_d, sram_q;

   // DUT 2: zero-fill disabled, request side idle
   logic          rst2_b;
   logic          req_vld2, req_wr2, rsp_rdy2;
   logic [AW-1:0] req_addr2;
   logic [DW-1:0] req_wdata2, req_wmask2, sram_q2;
   logic          req_rdy2, rsp_vld2, init_done2, sram_cen2, sram_gwen2;
   logic [DW-1:0] rsp_rdata2, sram_wen2, sram_d2;
   logic [AW-1:0] sram_a2;

   int n_chk  = 0;
   int n_fail = 0;

   ct_f_spsram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(1)) u_dut (
      .forever_cpuclk (clk),       .cpurst_b  (rst_b),
      .req_vld  (req_vld),         .req_rdy   (req_rdy),
      .req_wr   (req_wr),          .req_addr  (req_addr),
      .req_wdata(req_wdata),       .req_wmask (req_wmask),
      .rsp_vld  (rsp_vld),         .rsp_rdy   (rsp_rdy),
      .rsp_rdata(rsp_rdata),       .init_done (init_done),
      .sram_a   (sram_a),          .sram_cen  (sram_cen),
      .sram_gwen(sram_gwen),       .sram_wen  (sram_wen),
      .sram_d   (sram_d),          .sram_q    (sram_q)
   );

   ct_f_spsram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .INIT_EN(0)) u_dut2 (
      .forever_cpuclk (clk),       .cpurst_b  (rst2_b),
      .req_vld  (req_vld2),        .req_rdy   (req_rdy2),
      .req_wr   (req_wr2),         .req_addr  (req_addr2),
      .req_wdata(req_wdata2),      .req_wmask (req_wmask2),
      .rsp_vld  (rsp_vld2),        .rsp_rdy   (rsp_rdy2),
      .rsp_rdata(rsp_rdata2),      .init_done (init_done2),
      .sram_a   (sram_a2),         .sram_cen  (sram_cen2),
      .sram_gwen(sram_gwen2),      .sram_wen  (sram_wen2),
      .sram_d   (sram_d2),         .sram_q    (sram_q2)
   );

   // Behavioural single-port SRAM: registered Q, held while CEN is high.
   logic [DW-1:0] mem [DEPTH];
   always @(posedge clk) begin
      if (!sram_cen) begin
         if (!sram_gwen) mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
         else            sram_q      <= mem[sram_a];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Scoreboard: reference memory updated from accepted writes; expected read
   // data queued on accepted reads and compared when the response is taken.
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] sb_q [$];
   logic [DW-1:0] sb_exp;
   always @(negedge clk) begin
      if (!rst_b) begin
         sb_q.delete();
         for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end else begin
         if (rsp_vld && rsp_rdy) begin
            if (sb_q.size() == 0) begin
               chk("rsp_unexpected", 1, 0);
            end else begin
               sb_exp = sb_q.pop_front();
               chk("rsp_data", rsp_rdata, sb_exp);
            end
         end
         if (req_vld && req_rdy) begin
            if (req_wr) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
            else        sb_q.push_back(ref_mem[req_addr]);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0; req_wmask = '0;
   endtask

   task automatic drive(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [DW-1:0] m);
      req_vld = 1'b1; req_wr = wr; req_addr = a; req_wdata = d; req_wmask = m;
   endtask

   task automatic wr_op(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
      drive(1'b1, a, d, m);
      #1;
      chk("wr_rdy", req_rdy, 1);
      step();
      idle();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
      sram_q = '0;
      idle();
      rsp_rdy = 1'b1;
      rst_b = 1'b0; rst2_b = 1'b0;
      req_vld2 = 1'b0; req_wr2 = 1'b0; req_addr2 = '0; req_wdata2 = '0; req_wmask2 = '0;
      rsp_rdy2 = 1'b1; sram_q2 = '0;

      // Reset values
      repeat (3) step();
      chk("rst_req_rdy", req_rdy, 0);
      chk("rst_rsp_vld", rsp_vld, 0);
      chk("rst_init_done", init_done, 0);
      chk("rst_cen", sram_cen, 1);
      chk("rst_gwen", sram_gwen, 1);
      chk("rst_wen", sram_wen, 16'hFFFF);
      chk("rst_a", sram_a, 0);
      chk("rst_d", sram_d, 0);
      chk("rst2_init_done", init_done2, 0);

      // Zero-fill: cycle 0 idle, cycles 1..16 write A=0..15, cycle 17 ready
      rst_b = 1'b1;
      #1;
      chk("c0_cen", sram_cen, 1);
      chk("c0_init_done", init_done, 0);
      for (int i = 0; i < DEPTH; i++) begin
         step();
         chk("fill_cen", sram_cen, 0);
         chk("fill_gwen", sram_gwen, 0);
         chk("fill_wen", sram_wen, 0);
         chk("fill_a", sram_a, i);
         chk("fill_d", sram_d, 0);
         chk("fill_init_done", init_done, 0);
      end
      step();
      chk("c17_init_done", init_done, 1);
      chk("c17_req_rdy", req_rdy, 1);
      chk("c17_cen", sram_cen, 1);

      // Write 5 then read 5
      drive(1'b1, 4'd5, 16'hA5A5, 16'hFFFF);
      #1;
      chk("wr_cen", sram_cen, 0);
      chk("wr_gwen", sram_gwen, 0);
      chk("wr_wen", sram_wen, 16'h0000);
      chk("wr_d", sram_d, 16'hA5A5);
      chk("wr_a", sram_a, 5);
      step();
      drive(1'b0, 4'd5, 16'h0, 16'h0);
      #1;
      chk("rd_rdy", req_rdy, 1);
      chk("rd_cen", sram_cen, 0);
      chk("rd_gwen", sram_gwen, 1);
      chk("rd_wen", sram_wen, 16'hFFFF);
      step();
      idle();
      #1;
      chk("rd_lat_vld", rsp_vld, 1);
      chk("rd5_data", rsp_rdata, 16'hA5A5);
      step();
      chk("rd_vld_clr", rsp_vld, 0);

      // Partial-mask and zero-mask writes
      wr_op(4'd6, 16'hFFFF, 16'h00F0);
      wr_op(4'd5, 16'h0000, 16'h0000);
      drive(1'b0, 4'd6, 16'h0, 16'h0); step();
      drive(1'b0, 4'd5, 16'h0, 16'h0); #1;
      chk("rd6_data", rsp_rdata, 16'h00F0);
      step();
      idle(); #1;
      chk("rd5_zero_mask", rsp_rdata, 16'hA5A5);
      step();

      // Back-to-back reads 1, 2, 3
      wr_op(4'd1, 16'h1111, 16'hFFFF);
      wr_op(4'd2, 16'h2222, 16'hFFFF);
      wr_op(4'd3, 16'h3333, 16'hFFFF);
      wr_op(4'd7, 16'h7777, 16'hFFFF);
      for (int k = 1; k <= 3; k++) begin
         drive(1'b0, AW'(k), 16'h0, 16'h0);
         #1;
         chk("b2b_rdy", req_rdy, 1);
         if (k > 1) chk("b2b_vld", rsp_vld, 1);
         step();
      end
      idle(); #1;
      chk("b2b_vld_last", rsp_vld, 1);
      step();
      chk("b2b_vld_clr", rsp_vld, 0);

      // Backpressure on read of 7 with a pending read of 3
      drive(1'b0, 4'd7, 16'h0, 16'h0);
      step();
      rsp_rdy = 1'b0;
      drive(1'b0, 4'd3, 16'h0, 16'h0);
      repeat (4) begin
         #1;
         chk("bp_rdy", req_rdy, 0);
         chk("bp_cen", sram_cen, 1);
         chk("bp_vld", rsp_vld, 1);
         chk("bp_rdata", rsp_rdata, 16'h7777);
         step();
      end
      rsp_rdy = 1'b1;
      #1;
      chk("bp_release_rdy", req_rdy, 1);
      chk("bp_release_cen", sram_cen, 0);
      chk("bp_release_a", sram_a, 3);
      step();
      idle(); #1;
      chk("bp_next_vld", rsp_vld, 1);
      chk("bp_next_data", rsp_rdata, 16'h3333);
      step();
      chk("bp_vld_clr", rsp_vld, 0);

      // Write fires in the cycle the response is consumed
      drive(1'b0, 4'd1, 16'h0, 16'h0);
      step();
      drive(1'b1, 4'd2, 16'h2D2D, 16'hFFFF);
      #1;
      chk("wc_rdy", req_rdy, 1);
      step();
      idle(); #1;
      chk("wc_vld", rsp_vld, 0);

      // Reset with a response pending, then reset again mid-fill at A=9
      drive(1'b0, 4'd5, 16'h0, 16'h0);
      step();
      idle();
      rsp_rdy = 1'b0;
      #1;
      chk("rr_vld_before", rsp_vld, 1);
      rst_b = 1'b0;
      step();
      chk("rr_vld", rsp_vld, 0);
      chk("rr_init_done", init_done, 0);
      chk("rr_req_rdy", req_rdy, 0);
      rsp_rdy = 1'b1;
      rst_b = 1'b1;
      repeat (10) step();
      chk("mid_a9", sram_a, 9);
      chk("mid_cen", sram_cen, 0);
      rst_b = 1'b0;
      step();
      chk("mid_rst_cen", sram_cen, 1);
      chk("mid_rst_a", sram_a, 0);
      rst_b = 1'b1;
      #1;
      chk("refill_c0_cen", sram_cen, 1);
      for (int i = 0; i < DEPTH; i++) begin
         step();
         chk("refill_a", sram_a, i);
         chk("refill_init_done", init_done, 0);
      end
      step();
      chk("refill_done", init_done, 1);
      drive(1'b0, 4'd5, 16'h0, 16'h0);
      step();
      idle(); #1;
      chk("refill_rd5", rsp_rdata, 16'h0000);
      step();

      // INIT_EN = 0
      rst2_b = 1'b1;
      #1;
      chk("noinit_c0_done", init_done2, 0);
      chk("noinit_c0_cen", sram_cen2, 1);
      step();
      chk("noinit_c1_done", init_done2, 1);
      chk("noinit_c1_rdy", req_rdy2, 1);
      repeat (3) begin
         chk("noinit_cen", sram_cen2, 1);
         step();
      end

      chk("sb_empty", sb_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
